fabric_driver: RTL and testbench
================================

Name: fabric_driver

Overview:
- Writer-side counterpart of the node wrapper block: accepts stimulus bytes from the chip IO and assembles them into the four nibble inputs the block samples.
- Holds each frame stable long enough for the block to register it and waits for the block's ready flag.
- Captures the block's output nibble and returns it to the IO side over a valid/ready handshake.
- Sits between the top-level pin mux and one block instance.

Parameters:
- W, 4, nibble width; matches the block's in1..in4 and out width.
- HOLD_CYCLES, 2, minimum cycles a frame is held on drv_in* before capture; legal range 1..15.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  2W  stimulus byte; low frame byte = {in2,in1}, high frame byte = {in4,in3}.
- in_valid  input  1  in_data valid.
- in_ready  output  1  driver accepts a byte this cycle.
- drv_in1..drv_in4  output  W each  registered nibbles to the block's in1..in4.
- blk_out  input  W  block output nibble.
- blk_rdy  input  1  block ready flag.
- res_data  output  W  captured block output.
- res_valid  output  1  res_data valid.
- res_ready  input  1  consumer accepts res_data.
- busy  output  1  a frame is in progress (state != WAIT_LO).
- frame_count  output  8  completed frames; wraps 255 -> 0.

Behaviour:
- Reset (rst=1 at a posedge): state=WAIT_LO; drv_in1..4=0; res_data=0; res_valid=0; frame_count=0; staging register=0; hold counter=0. Reset mid-frame discards the staged byte and any pending result.
- A byte transfer occurs on a posedge with in_valid && in_ready.
- in_ready = 1 only in WAIT_LO and WAIT_HI. busy = (state != WAIT_LO).
- WAIT_LO: on transfer, stage in_data and go to WAIT_HI. Otherwise stay.
- WAIT_HI: on transfer, load all four drv_in registers on the same edge (drv_in1/2 from the staged byte, drv_in3/4 from in_data), set counter=HOLD_CYCLES-1, and go to APPLY. The block never sees a half-updated frame.
- APPLY:
  - If counter != 0, decrement.
  - If counter == 0 and blk_rdy == 1, go to CAPTURE.
  - If counter == 0 and blk_rdy == 0, stay with counter held at 0.
- CAPTURE: the result slot is free when !res_valid || res_ready.
  - If free: res_data <= blk_out, res_valid <= 1, frame_count++, go to WAIT_LO.
  - If not free: stay (backpressure); drv_in stays held and no byte is accepted.
- res_valid clears on an edge with res_valid && res_ready, unless a new capture happens on the same edge; the capture wins and res_valid stays 1.
- drv_in1..4 hold their last frame between frames and are never cleared except by reset.
- Latency with blk_rdy=1 and the slot free: high-byte transfer at edge t -> drv_in valid after t -> CAPTURE entered at edge t+HOLD_CYCLES -> res_valid=1 after edge t+HOLD_CYCLES+1. For HOLD_CYCLES=2, res_valid rises 3 cycles after the high-byte transfer.
- Minimum frame period is HOLD_CYCLES+3 cycles: 2 bytes + hold + capture.
- frame_count is 8-bit modulo.

Decomposition:
- Shared package fabric_pkg holds:
  - State encoding localparams: WAIT_LO=2'd0, WAIT_HI=2'd1, APPLY=2'd2, CAPTURE=2'd3.
  - Default nibble width NIB_W=4, shared with the block.
  - Byte-lane mapping constants: LO_BYTE -> in1/in2, HI_BYTE -> in3/in4.
- Single module; the hold counter is inline. A sub-module is not warranted.

Test Plan:
- Reset then idle -> in_ready=1, busy=0, drv_in1..4=0, res_valid=0, frame_count=0.
- Send 0x21, then 0x43 (in_valid held, blk_rdy=1, res_ready=1, blk_out=4'hA) -> drv_in1..4 = 1,2,3,4 updated on the same edge; res_valid=1 with res_data=A exactly 3 cycles after the second byte; frame_count=1.
- Hold blk_rdy=0 for 5 cycles after frame load -> stays in APPLY, in_ready=0; capture occurs 1 cycle after blk_rdy rises.
- Backpressure: res_ready=0 with a result pending, then a second frame -> driver waits in CAPTURE, drv_in holds the frame; res_ready=1 for one cycle -> old result popped and new result loaded on the same edge, res_valid stays 1.
- Assert rst while in WAIT_HI after byte 0x21 -> all outputs return to reset values; next byte 0x65 is treated as the low byte.
- Run 256 frames -> frame_count wraps to 0; no dropped or duplicated results.

Source files
------------

// File: rtl/fabric_driver_pkg.sv
// Shared definitions for the fabric driver: state encoding, nibble width and
// the mapping of stimulus bytes onto the block's four nibble inputs.
package fabric_pkg;

  localparam int NIB_W = 4;
  localparam int CNT_W = 4;

  // Frame byte order: the low byte feeds in1/in2 and the high byte feeds in3/in4.
  localparam int LO_BYTE = 0;
  localparam int HI_BYTE = 1;

  typedef enum logic [1:0] {
    WAIT_LO = 2'd0,
    WAIT_HI = 2'd1,
    APPLY   = 2'd2,
    CAPTURE = 2'd3
  } state_t;

endpackage

// File: rtl/fabric_driver_if.sv
// Bundle of the IO-side stimulus/result handshakes and the block-side nibble bus.
interface fabric_driver_if
  import fabric_pkg::*;
#(
  parameter int W = NIB_W
) ();

  logic [2*W-1:0] in_data;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   drv_in1;
  logic [W-1:0]   drv_in2;
  logic [W-1:0]   drv_in3;
  logic [W-1:0]   drv_in4;
  logic [W-1:0]   blk_out;
  logic           blk_rdy;
  logic [W-1:0]   res_data;
  logic           res_valid;
  logic           res_ready;
  logic           busy;
  logic [7:0]     frame_count;

  modport master (
    input  in_data, in_valid, blk_out, blk_rdy, res_ready,
    output in_ready, drv_in1, drv_in2, drv_in3, drv_in4,
           res_data, res_valid, busy, frame_count
  );

  modport slave (
    output in_data, in_valid, blk_out, blk_rdy, res_ready,
    input  in_ready, drv_in1, drv_in2, drv_in3, drv_in4,
           res_data, res_valid, busy, frame_count
  );

endinterface

// File: rtl/fabric_driver.sv
// Assembles two stimulus bytes into a four-nibble frame, holds it for the block,
// then captures the block's output nibble into a valid/ready result slot.
module fabric_driver
  import fabric_pkg::*;
#(
  parameter int W           = NIB_W,
  parameter int HOLD_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  fabric_driver_if.master bus
);

  state_t           state_r, state_s;
  logic [2*W-1:0]   stage_r, stage_s;
  logic [W-1:0]     drv1_r, drv1_s, drv2_r, drv2_s, drv3_r, drv3_s, drv4_r, drv4_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [W-1:0]     res_data_r, res_data_s;
  logic             res_valid_r, res_valid_s;
  logic [7:0]       frame_count_r, frame_count_s;
  logic             in_ready_r, in_ready_s;
  logic             busy_r, busy_s;
  logic             xfer_s;
  logic             slot_free_s;

  assign xfer_s      = bus.in_valid && in_ready_r;
  assign slot_free_s = !res_valid_r || bus.res_ready;

  // Next-state and datapath decode; all outputs are taken from registers.
  always_comb begin
    state_s       = state_r;
    stage_s       = stage_r;
    drv1_s        = drv1_r;
    drv2_s        = drv2_r;
    drv3_s        = drv3_r;
    drv4_s        = drv4_r;
    cnt_s         = cnt_r;
    res_data_s    = res_data_r;
    frame_count_s = frame_count_r;

    if (res_valid_r && bus.res_ready) begin
      res_valid_s = 1'b0;
    end else begin
      res_valid_s = res_valid_r;
    end

    case (state_r)
      WAIT_LO: begin
        if (xfer_s) begin
          stage_s = bus.in_data;
          state_s = WAIT_HI;
        end else begin
          state_s = WAIT_LO;
        end
      end
      WAIT_HI: begin
        // All four nibbles change on one edge so the block never sees a torn frame.
        if (xfer_s) begin
          drv1_s  = stage_r[0 +: W];
          drv2_s  = stage_r[W +: W];
          drv3_s  = bus.in_data[0 +: W];
          drv4_s  = bus.in_data[W +: W];
          cnt_s   = CNT_W'(HOLD_CYCLES - 1);
          state_s = APPLY;
        end else begin
          state_s = WAIT_HI;
        end
      end
      APPLY: begin
        if (cnt_r != {CNT_W{1'b0}}) begin
          cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (bus.blk_rdy) begin
          state_s = CAPTURE;
        end else begin
          state_s = APPLY;
        end
      end
      CAPTURE: begin
        // A capture on the same edge as a pop keeps res_valid high.
        if (slot_free_s) begin
          res_data_s    = bus.blk_out;
          res_valid_s   = 1'b1;
          frame_count_s = frame_count_r + 8'd1;
          state_s       = WAIT_LO;
        end else begin
          state_s = CAPTURE;
        end
      end
      default: begin
        state_s = WAIT_LO;
      end
    endcase

    in_ready_s = (state_s == WAIT_LO) || (state_s == WAIT_HI);
    busy_s     = (state_s != WAIT_LO);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= WAIT_LO;
      stage_r       <= {(2*W){1'b0}};
      drv1_r        <= {W{1'b0}};
      drv2_r        <= {W{1'b0}};
      drv3_r        <= {W{1'b0}};
      drv4_r        <= {W{1'b0}};
      cnt_r         <= {CNT_W{1'b0}};
      res_data_r    <= {W{1'b0}};
      res_valid_r   <= 1'b0;
      frame_count_r <= 8'd0;
      in_ready_r    <= 1'b1;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      stage_r       <= stage_s;
      drv1_r        <= drv1_s;
      drv2_r        <= drv2_s;
      drv3_r        <= drv3_s;
      drv4_r        <= drv4_s;
      cnt_r         <= cnt_s;
      res_data_r    <= res_data_s;
      res_valid_r   <= res_valid_s;
      frame_count_r <= frame_count_s;
      in_ready_r    <= in_ready_s;
      busy_r        <= busy_s;
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.busy        = busy_r;
  assign bus.drv_in1     = drv1_r;
  assign bus.drv_in2     = drv2_r;
  assign bus.drv_in3     = drv3_r;
  assign bus.drv_in4     = drv4_r;
  assign bus.res_data    = res_data_r;
  assign bus.res_valid   = res_valid_r;
  assign bus.frame_count = frame_count_r;

endmodule

// File: tb/tb_fabric_driver.sv
// Directed self-checking bench for fabric_driver with HOLD_CYCLES=2.
module tb_fabric_driver;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  fabric_driver_if #(.W(4)) bus ();

  fabric_driver #(.W(4), .HOLD_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one byte and holds it until the driver accepts it (bounded).
  task automatic send_byte(input logic [7:0] b);
    logic acc;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    acc = 1'b0;
    for (int k = 0; k < 60 && !acc; k++) begin
      acc = bus.in_ready;
      tick();
    end
    bus.in_valid = 1'b0;
    if (!acc) begin
      total++; bad++;
      $display("FAIL send_byte timeout: byte=%h in_ready=%b required accept", b, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    total++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL reset_hs: in_ready=%b busy=%b required 1 0", bus.in_ready, bus.busy);
    end
    total++;
    if ({bus.drv_in4, bus.drv_in3, bus.drv_in2, bus.drv_in1} !== 16'h0000) begin
      bad++; $display("FAIL reset_drv: got %h required 0000", {bus.drv_in4, bus.drv_in3, bus.drv_in2, bus.drv_in1});
    end
    total++;
    if (bus.res_valid !== 1'b0 || bus.res_data !== 4'h0 || bus.frame_count !== 8'd0) begin
      bad++; $display("FAIL reset_res: valid=%b data=%h count=%0d required 0 0 0", bus.res_valid, bus.res_data, bus.frame_count);
    end
  endtask

  task automatic test_basic();
    bus.blk_rdy = 1'b1; bus.res_ready = 1'b1; bus.blk_out = 4'hA;
    send_byte(8'h21);
    total++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1 || bus.drv_in1 !== 4'h0) begin
      bad++; $display("FAIL basic_lo: busy=%b in_ready=%b drv1=%h required 1 1 0", bus.busy, bus.in_ready, bus.drv_in1);
    end
    send_byte(8'h43);
    total++;
    if ({bus.drv_in4, bus.drv_in3, bus.drv_in2, bus.drv_in1} !== 16'h4321 || bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL basic_load: drv=%h in_ready=%b required 4321 0", {bus.drv_in4, bus.drv_in3, bus.drv_in2, bus.drv_in1}, bus.in_ready);
    end
    for (int k = 1; k <= 2; k++) begin
      tick();
      total++;
      if (bus.res_valid !== 1'b0) begin
        bad++; $display("FAIL basic_early: cycle %0d res_valid=%b required 0", k, bus.res_valid);
      end
    end
    tick();
    total++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 4'hA || bus.frame_count !== 8'd1 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL basic_result: valid=%b data=%h count=%0d busy=%b required 1 a 1 0", bus.res_valid, bus.res_data, bus.frame_count, bus.busy);
    end
    tick();
    total++;
    if (bus.res_valid !== 1'b0) begin
      bad++; $display("FAIL basic_pop: res_valid=%b required 0", bus.res_valid);
    end
  endtask

  task automatic test_stall();
    bus.blk_rdy = 1'b0; bus.blk_out = 4'h3;
    send_byte(8'h87);
    send_byte(8'h65);
    for (int k = 0; k < 5; k++) begin
      total++;
      if (bus.in_ready !== 1'b0 || bus.res_valid !== 1'b0 || bus.busy !== 1'b1) begin
        bad++; $display("FAIL stall_hold: cycle %0d in_ready=%b res_valid=%b busy=%b required 0 0 1", k, bus.in_ready, bus.res_valid, bus.busy);
      end
      if (k < 4) tick();
    end
    total++;
    if ({bus.drv_in4, bus.drv_in3, bus.drv_in2, bus.drv_in1} !== 16'h6587) begin
      bad++; $display("FAIL stall_drv: got %h required 6587", {bus.drv_in4, bus.drv_in3, bus.drv_in2, bus.drv_in1});
    end
    bus.blk_rdy = 1'b1;
    tick();
    total++;
    if (bus.res_valid !== 1'b0) begin
      bad++; $display("FAIL stall_capture_edge: res_valid=%b required 0", bus.res_valid);
    end
    tick();
    total++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 4'h3 || bus.frame_count !== 8'd2) begin
      bad++; $display("FAIL stall_result: valid=%b data=%h count=%0d required 1 3 2", bus.res_valid, bus.res_data, bus.frame_count);
    end
    tick();
  endtask

  task automatic test_backpressure();
    bus.res_ready = 1'b0; bus.blk_rdy = 1'b1; bus.blk_out = 4'h5;
    send_byte(8'h21);
    send_byte(8'h43);
    tick(); tick(); tick();
    total++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 4'h5 || bus.frame_count !== 8'd3) begin
      bad++; $display("FAIL bp_first: valid=%b data=%h count=%0d required 1 5 3", bus.res_valid, bus.res_data, bus.frame_count);
    end
    bus.blk_out = 4'h9;
    send_byte(8'hBA);
    send_byte(8'hDC);
    bus.in_valid = 1'b1; bus.in_data = 8'hFF;
    for (int k = 0; k < 4; k++) tick();
    total++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.res_data !== 4'h5 || bus.res_valid !== 1'b1) begin
      bad++; $display("FAIL bp_wait: busy=%b in_ready=%b data=%h valid=%b required 1 0 5 1", bus.busy, bus.in_ready, bus.res_data, bus.res_valid);
    end
    total++;
    if ({bus.drv_in4, bus.drv_in3, bus.drv_in2, bus.drv_in1} !== 16'hDCBA || bus.frame_count !== 8'd3) begin
      bad++; $display("FAIL bp_held: drv=%h count=%0d required dcba 3", {bus.drv_in4, bus.drv_in3, bus.drv_in2, bus.drv_in1}, bus.frame_count);
    end
    bus.in_valid = 1'b0;
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    total++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 4'h9 || bus.frame_count !== 8'd4 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL bp_swap: valid=%b data=%h count=%0d busy=%b required 1 9 4 0", bus.res_valid, bus.res_data, bus.frame_count, bus.busy);
    end
    bus.res_ready = 1'b1;
    tick();
    total++;
    if (bus.res_valid !== 1'b0) begin
      bad++; $display("FAIL bp_drain: res_valid=%b required 0", bus.res_valid);
    end
  endtask

  task automatic test_reset_mid();
    bus.blk_out = 4'hE;
    send_byte(8'h21);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.frame_count !== 8'd0 ||
        {bus.drv_in4, bus.drv_in3, bus.drv_in2, bus.drv_in1} !== 16'h0000) begin
      bad++; $display("FAIL mid_reset: busy=%b in_ready=%b count=%0d drv=%h required 0 1 0 0000",
                      bus.busy, bus.in_ready, bus.frame_count, {bus.drv_in4, bus.drv_in3, bus.drv_in2, bus.drv_in1});
    end
    send_byte(8'h65);
    send_byte(8'h87);
    total++;
    if ({bus.drv_in4, bus.drv_in3, bus.drv_in2, bus.drv_in1} !== 16'h8765) begin
      bad++; $display("FAIL mid_relo: drv=%h required 8765", {bus.drv_in4, bus.drv_in3, bus.drv_in2, bus.drv_in1});
    end
    tick(); tick(); tick();
    total++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 4'hE || bus.frame_count !== 8'd1) begin
      bad++; $display("FAIL mid_result: valid=%b data=%h count=%0d required 1 e 1", bus.res_valid, bus.res_data, bus.frame_count);
    end
    tick();
  endtask

  task automatic test_wrap();
    logic [7:0] lo, hi, exp_cnt;
    logic [3:0] exp_out;
    logic       seen;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.res_ready = 1'b1; bus.blk_rdy = 1'b1;
    for (int i = 0; i < 256; i++) begin
      lo      = 8'(i);
      hi      = 8'(i * 7 + 3);
      exp_out = 4'(i) ^ 4'h5;
      exp_cnt = 8'(i + 1);
      bus.blk_out = exp_out;
      send_byte(lo);
      send_byte(hi);
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        if (bus.res_valid) seen = 1'b1;
        else tick();
      end
      total++;
      if (!seen || bus.res_data !== exp_out || bus.frame_count !== exp_cnt ||
          {bus.drv_in4, bus.drv_in3, bus.drv_in2, bus.drv_in1} !== {hi, lo}) begin
        bad++; $display("FAIL wrap_frame %0d: seen=%b data=%h count=%0d drv=%h required 1 %h %0d %h",
                        i, seen, bus.res_data, bus.frame_count, {bus.drv_in4, bus.drv_in3, bus.drv_in2, bus.drv_in1},
                        exp_out, exp_cnt, {hi, lo});
      end
      tick();
      total++;
      if (bus.res_valid !== 1'b0) begin
        bad++; $display("FAIL wrap_dup %0d: res_valid=%b required 0", i, bus.res_valid);
      end
    end
    total++;
    if (bus.frame_count !== 8'd0) begin
      bad++; $display("FAIL wrap_final: count=%0d required 0", bus.frame_count);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.blk_out   = 4'h0;
    bus.blk_rdy   = 1'b0;
    bus.res_ready = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
